multi_alarm_ctrl: RTL and testbench

Parametrised alarm controller for the alarm-with-sound design. It holds `N_ALARMS` independently programmable BCD alarm times and compares them against the watch's current time on each minute boundary. It runs a ring/snooze/timeout state machine and drives the `aud_en` input of the sound generator. It replaces the single-alarm sound control path and sits between the BCD watch counter and the PWM sound block.

---
 rtl/multi_alarm_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot BCD alarm controller: programmable slots, minute-boundary match, ring/snooze/timeout FSM.
// Optional build macro ALARM_ONESHOT_EN: a slot disarms itself when it triggers.
module multi_alarm_ctrl #(
  parameter int N_ALARMS         = 4,
  parameter int IDX_W            = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             min_tick,
  input  logic [15:0]      now_time,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [15:0]      wr_time,
  input  logic             wr_arm,
  output logic             wr_err,
  input  logic             snooze_req,
  input  logic             stop_req,
  output logic             aud_en,
  output logic [IDX_W-1:0] ring_idx,
  output logic             snoozing,
  output logic             bud_state,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  localparam logic [3:0] SNZ_LOAD = 4'(SNOOZE_MIN);
  localparam logic [3:0] TO_LAST  = 4'(RING_TIMEOUT_MIN - 1);
  localparam logic [3:0] SNZ_MAX  = 4'(MAX_SNOOZE);

  logic [15:0]         slot_time_q [N_ALARMS];
  logic [N_ALARMS-1:0] slot_arm_q;
  logic [N_ALARMS-1:0] slot_arm_d;

  state_e              state_q;
  logic                aud_en_q;
  logic                snoozing_q;
  logic [IDX_W-1:0]    ring_idx_q;
  logic                wr_err_q;
  logic                bud_state_q;
  logic [3:0]          timeout_q;
  logic [3:0]          snz_left_q;
  logic [3:0]          snz_used_q;

  logic                wr_accept;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                trigger;
  logic                disarm_ring;

  // Write validation: slot in range, every digit decimal, hour <= 23, minute <= 59.
  always_comb begin
    logic [3:0] hd, ho, md, mo;
    logic       idx_ok, digits_ok, hour_ok;
    hd        = wr_time[15:12];
    ho        = wr_time[11:8];
    md        = wr_time[7:4];
    mo        = wr_time[3:0];
    idx_ok    = (32'(wr_idx) < 32'(N_ALARMS));
    digits_ok = (hd <= 4'd9) && (ho <= 4'd9) && (md <= 4'd5) && (mo <= 4'd9);
    hour_ok   = (hd < 4'd2) || ((hd == 4'd2) && (ho <= 4'd3));
    wr_accept = wr_en && idx_ok && digits_ok && hour_ok;
  end

  // Lowest-index armed slot wins: scan downwards so the last hit kept is the smallest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (slot_arm_q[i] && (slot_time_q[i] == now_time)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign trigger     = (state_q == ST_IDLE) && min_tick && hit;
  assign disarm_ring = wr_accept && !wr_arm && (wr_idx == ring_idx_q) && (state_q != ST_IDLE);

  always_comb begin
    slot_arm_d = slot_arm_q;
`ifdef ALARM_ONESHOT_EN
    for (int i = 0; i < N_ALARMS; i++) begin
      if (trigger && (32'(hit_idx) == i)) slot_arm_d[i] = 1'b0;
    end
`else
`endif
    for (int i = 0; i < N_ALARMS; i++) begin
      if (wr_accept && (32'(wr_idx) == i)) slot_arm_d[i] = wr_arm;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ALARMS; i++) slot_time_q[i] <= '0;
      slot_arm_q  <= '0;
      wr_err_q    <= 1'b0;
      bud_state_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (wr_accept && (32'(wr_idx) == i)) slot_time_q[i] <= wr_time;
      end
      slot_arm_q  <= slot_arm_d;
      wr_err_q    <= wr_en && !wr_accept;
      bud_state_q <= |slot_arm_d;
    end
  end

  // Requests outrank min_tick in the same cycle; stop (or disarming the ringing slot) outranks snooze.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      aud_en_q   <= 1'b0;
      snoozing_q <= 1'b0;
      ring_idx_q <= '0;
      timeout_q  <= '0;
      snz_left_q <= '0;
      snz_used_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q    <= ST_RING;
            aud_en_q   <= 1'b1;
            ring_idx_q <= hit_idx;
            timeout_q  <= '0;
            snz_used_q <= '0;
          end
        end
        ST_RING: begin
          if (stop_req || disarm_ring) begin
            state_q  <= ST_IDLE;
            aud_en_q <= 1'b0;
          end else if (snooze_req && (snz_used_q < SNZ_MAX)) begin
            state_q    <= ST_SNOOZE;
            aud_en_q   <= 1'b0;
            snoozing_q <= 1'b1;
            snz_left_q <= SNZ_LOAD;
            snz_used_q <= snz_used_q + 4'd1;
          end else if (min_tick) begin
            if (timeout_q >= TO_LAST) begin
              state_q  <= ST_IDLE;
              aud_en_q <= 1'b0;
            end else begin
              timeout_q <= timeout_q + 4'd1;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_req || disarm_ring) begin
            state_q    <= ST_IDLE;
            snoozing_q <= 1'b0;
          end else if (min_tick) begin
            if (snz_left_q <= 4'd1) begin
              state_q    <= ST_RING;
              aud_en_q   <= 1'b1;
              snoozing_q <= 1'b0;
              timeout_q  <= '0;
              snz_left_q <= '0;
            end else begin
              snz_left_q <= snz_left_q - 4'd1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          aud_en_q   <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign aud_en    = aud_en_q;
  assign snoozing  = snoozing_q;
  assign ring_idx  = ring_idx_q;
  assign wr_err    = wr_err_q;
  assign bud_state = bud_state_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl: programming, matching priority, snooze/timeout, stop and reset.
module tb_multi_alarm_ctrl;

  logic        clk;
  logic        rstn;
  logic        min_tick;
  logic [15:0] now_time;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [15:0] wr_time;
  logic        wr_arm;
  logic        wr_err;
  logic        snooze_req;
  logic        stop_req;
  logic        aud_en;
  logic [1:0]  ring_idx;
  logic        snoozing;
  logic        bud_state;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  multi_alarm_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .min_tick   (min_tick),
    .now_time   (now_time),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_time    (wr_time),
    .wr_arm     (wr_arm),
    .wr_err     (wr_err),
    .snooze_req (snooze_req),
    .stop_req   (stop_req),
    .aud_en     (aud_en),
    .ring_idx   (ring_idx),
    .snoozing   (snoozing),
    .bud_state  (bud_state),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need $finish before 200000ns");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge, outputs are read there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [15:0] t, input logic arm);
    wr_en = 1'b1; wr_idx = idx; wr_time = t; wr_arm = arm;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_tick(input logic [15:0] t);
    min_tick = 1'b1; now_time = t;
    step();
    min_tick = 1'b0;
  endtask

  task automatic do_snooze();
    snooze_req = 1'b1;
    step();
    snooze_req = 1'b0;
  endtask

  task automatic do_stop();
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) do_tick(16'h1200);
  endtask

  logic exp_bud_after_trig;
  logic exp_retrigger;

  initial begin
    checks = 0; failures = 0;
`ifdef ALARM_ONESHOT_EN
    exp_bud_after_trig = 1'b0;
    exp_retrigger      = 1'b0;
`else
    exp_bud_after_trig = 1'b1;
    exp_retrigger      = 1'b1;
`endif
    rstn = 1'b0; min_tick = 1'b0; now_time = '0; wr_en = 1'b0; wr_idx = '0;
    wr_time = '0; wr_arm = 1'b0; snooze_req = 1'b0; stop_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_aud", 32'(aud_en), 0);
    check_eq("rst_idx", 32'(ring_idx), 0);
    check_eq("rst_snz", 32'(snoozing), 0);
    check_eq("rst_err", 32'(wr_err), 0);
    check_eq("rst_bud", 32'(bud_state), 0);
    rstn = 1'b1;
    step();

    // cleared slots are 00:00 disarmed, so a 00:00 tick must not ring
    do_tick(16'h0000);
    check_eq("noarm_aud", 32'(aud_en), 0);

    do_write(2'd2, 16'h0730, 1'b1);
    check_eq("wr2_err", 32'(wr_err), 0);
    check_eq("wr2_bud", 32'(bud_state), 1);
    do_tick(16'h0729);
    check_eq("nomatch_aud", 32'(aud_en), 0);
    do_tick(16'h0730);
    check_eq("trig_aud", 32'(aud_en), 1);
    check_eq("trig_idx", 32'(ring_idx), 2);
    check_eq("trig_bud", 32'(bud_state), 32'(exp_bud_after_trig));
    check_eq("trig_state", 32'(dbg_state), 1);
    do_stop();
    check_eq("stop_aud", 32'(aud_en), 0);
    check_eq("stop_state", 32'(dbg_state), 0);
    do_tick(16'h0730);
    check_eq("retrig_aud", 32'(aud_en), 32'(exp_retrigger));
    do_stop();
    check_eq("retrig_stop", 32'(aud_en), 0);
    do_write(2'd2, 16'h0730, 1'b0);
    check_eq("disarm_bud", 32'(bud_state), 0);

    // priority: lowest index among equal armed slots
    do_write(2'd3, 16'h0600, 1'b1);
    do_write(2'd1, 16'h0600, 1'b1);
    do_tick(16'h0600);
    check_eq("prio_aud", 32'(aud_en), 1);
    check_eq("prio_idx", 32'(ring_idx), 1);

    // rejected writes pulse wr_err for one cycle and leave the ringing slot alone
    do_write(2'd1, 16'h2400, 1'b0);
    check_eq("bad2400_err", 32'(wr_err), 1);
    check_eq("bad2400_aud", 32'(aud_en), 1);
    step();
    check_eq("err_pulse", 32'(wr_err), 0);
    do_write(2'd1, 16'h126A, 1'b0);
    check_eq("bad126A_err", 32'(wr_err), 1);
    do_write(2'd1, 16'h1A00, 1'b0);
    check_eq("bad1A00_err", 32'(wr_err), 1);
    do_write(2'd1, 16'h2360, 1'b0);
    check_eq("bad2360_err", 32'(wr_err), 1);
    do_write(2'd0, 16'h2359, 1'b0);
    check_eq("ok2359_err", 32'(wr_err), 0);
    check_eq("other_wr_aud", 32'(aud_en), 1);
    check_eq("bud_slot3", 32'(bud_state), 1);

    do_write(2'd1, 16'h0600, 1'b0);
    check_eq("disarm_ring_aud", 32'(aud_en), 0);
    check_eq("disarm_ring_st", 32'(dbg_state), 0);

    // snooze cycles on slot 3
    do_tick(16'h0600);
    check_eq("s3_aud", 32'(aud_en), 1);
    check_eq("s3_idx", 32'(ring_idx), 3);
    for (int s = 0; s < 3; s++) begin
      do_snooze();
      check_eq("snz_aud", 32'(aud_en), 0);
      check_eq("snz_flag", 32'(snoozing), 1);
      idle_ticks(4);
      check_eq("snz4_aud", 32'(aud_en), 0);
      idle_ticks(1);
      check_eq("snz5_aud", 32'(aud_en), 1);
      check_eq("snz5_flag", 32'(snoozing), 0);
    end
    do_snooze();
    check_eq("snz_max_aud", 32'(aud_en), 1);
    check_eq("snz_max_flag", 32'(snoozing), 0);
    idle_ticks(9);
    check_eq("to9_aud", 32'(aud_en), 1);
    idle_ticks(1);
    check_eq("to10_aud", 32'(aud_en), 0);

    // fresh trigger times out after exactly 10 ticks
    do_write(2'd3, 16'h0600, 1'b1);
    do_tick(16'h0600);
    check_eq("fresh_aud", 32'(aud_en), 1);
    idle_ticks(9);
    check_eq("fresh9_aud", 32'(aud_en), 1);
    idle_ticks(1);
    check_eq("fresh10_aud", 32'(aud_en), 0);

    // stop beats snooze
    do_write(2'd3, 16'h0600, 1'b1);
    do_tick(16'h0600);
    stop_req = 1'b1; snooze_req = 1'b1;
    step();
    stop_req = 1'b0; snooze_req = 1'b0;
    check_eq("both_aud", 32'(aud_en), 0);
    check_eq("both_snz", 32'(snoozing), 0);
    check_eq("both_state", 32'(dbg_state), 0);

    // snooze with a same-cycle tick: tick discarded, full snooze length follows
    do_write(2'd3, 16'h0600, 1'b1);
    do_tick(16'h0600);
    snooze_req = 1'b1; min_tick = 1'b1; now_time = 16'h1200;
    step();
    snooze_req = 1'b0; min_tick = 1'b0;
    check_eq("snztick_flag", 32'(snoozing), 1);
    idle_ticks(4);
    check_eq("snztick4_aud", 32'(aud_en), 0);
    idle_ticks(1);
    check_eq("snztick5_aud", 32'(aud_en), 1);
    do_stop();

    // asynchronous reset while snoozing
    do_write(2'd3, 16'h0600, 1'b1);
    do_tick(16'h0600);
    do_snooze();
    check_eq("pre_rst_snz", 32'(snoozing), 1);
    rstn = 1'b0;
    #1;
    check_eq("arst_aud", 32'(aud_en), 0);
    check_eq("arst_snz", 32'(snoozing), 0);
    check_eq("arst_idx", 32'(ring_idx), 0);
    check_eq("arst_bud", 32'(bud_state), 0);
    check_eq("arst_state", 32'(dbg_state), 0);
    step();
    rstn = 1'b1;
    step();
    do_tick(16'h0600);
    check_eq("post_rst_aud", 32'(aud_en), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
